vliw_fetch_queue: RTL and testbench

- Parametrised fetch stage for the VLIW core; successor to the fixed three-slot fetch register.
- Accepts a bundle word plus per-lane immediate data over a valid/ready handshake and slices it into per-lane opcode, src1, src2 and dest fields.
- Queues decoded bundles in a DEPTH-entry FIFO so fetch can run ahead of a stalled decode stage. Supports flush and optional all-NOP bundle dropping.
- Sits between instruction memory and decode/register-read.

---
 rtl/vliw_pkg.sv | 53 +++++
 rtl/vliw_bundle_fifo.sv | 64 ++++++
 rtl/vliw_fetch_queue.sv | 101 ++++++++++
 tb/tb_vliw_fetch_queue.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_pkg.sv
// vliw_pkg: shared encodings for the VLIW front end.
//   - opcode codes (nop .. bshiftright), register codes (reg0 .. reg15)
//   - lane slot geometry: SLOT_W bits per lane, 4-bit fields at fixed offsets
//   - helper to size a bundle word for a given lane count
package vliw_pkg;

  localparam logic [3:0] nop         = 4'd0;
  localparam logic [3:0] add         = 4'd1;
  localparam logic [3:0] sub         = 4'd2;
  localparam logic [3:0] mul         = 4'd3;
  localparam logic [3:0] load        = 4'd4;
  localparam logic [3:0] move        = 4'd5;
  localparam logic [3:0] read        = 4'd6;
  localparam logic [3:0] compare     = 4'd7;
  localparam logic [3:0] xorinst     = 4'd8;
  localparam logic [3:0] nandinst    = 4'd9;
  localparam logic [3:0] norinst     = 4'd10;
  localparam logic [3:0] notinst     = 4'd11;
  localparam logic [3:0] shiftleft   = 4'd12;
  localparam logic [3:0] shiftright  = 4'd13;
  localparam logic [3:0] bshiftleft  = 4'd14;
  localparam logic [3:0] bshiftright = 4'd15;

  localparam logic [3:0] reg0  = 4'd0;
  localparam logic [3:0] reg1  = 4'd1;
  localparam logic [3:0] reg2  = 4'd2;
  localparam logic [3:0] reg3  = 4'd3;
  localparam logic [3:0] reg4  = 4'd4;
  localparam logic [3:0] reg5  = 4'd5;
  localparam logic [3:0] reg6  = 4'd6;
  localparam logic [3:0] reg7  = 4'd7;
  localparam logic [3:0] reg8  = 4'd8;
  localparam logic [3:0] reg9  = 4'd9;
  localparam logic [3:0] reg10 = 4'd10;
  localparam logic [3:0] reg11 = 4'd11;
  localparam logic [3:0] reg12 = 4'd12;
  localparam logic [3:0] reg13 = 4'd13;
  localparam logic [3:0] reg14 = 4'd14;
  localparam logic [3:0] reg15 = 4'd15;

  localparam int SLOT_W   = 20;
  localparam int FIELD_W  = 4;
  localparam int OPC_OFS  = 15;
  localparam int SRC1_OFS = 10;
  localparam int SRC2_OFS = 5;
  localparam int DEST_OFS = 0;
  localparam int RSVD_W   = 4;

  function automatic int bundle_word_w(input int num_slots);
    return SLOT_W * num_slots + RSVD_W;
  endfunction

endpackage

// File: rtl/vliw_bundle_fifo.sv
// vliw_bundle_fifo: generic DEPTH-entry FIFO with flush and level output.
//   clock, reset (sync, active-low), flush (clears pointers and level)
//   push/wr_data: write when not full; pop: advance head when not empty
//   rd_data: storage at head (may be stale when empty; caller masks it)
//   level/full/empty: occupancy
module vliw_bundle_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     wr_data,
  input  logic             pop,
  output logic [W-1:0]     rd_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  // Storage is deliberately not reset; the top masks head data while empty.
  always_ff @(posedge clock) begin
    if (reset && do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vliw_fetch_queue.sv
// vliw_fetch_queue: VLIW fetch stage. Slices a bundle word into per-lane
// opcode/src1/src2/dest, gates each lane's immediate by its own load opcode,
// and queues decoded bundles in a FIFO ahead of decode.
//   clock, reset (sync, active-low), flush (drop queue and current offer)
//   in_valid/in_ready/in_word/in_data   : bundle input handshake
//   out_valid/out_ready                 : head handshake to decode
//   out_op/out_src1/out_src2/out_dest   : lane i at [4*i +: 4]
//   out_data                            : lane i at [DATA_W*i +: DATA_W]
//   level                               : entries held
module vliw_fetch_queue
  import vliw_pkg::*;
#(
  parameter int NUM_SLOTS = 3,
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 4,
  parameter bit DROP_NOP  = 1'b0,
  localparam int WORD_W   = SLOT_W * NUM_SLOTS + RSVD_W,
  localparam int LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_word,
  input  logic [NUM_SLOTS*DATA_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [4*NUM_SLOTS-1:0]      out_op,
  output logic [4*NUM_SLOTS-1:0]      out_src1,
  output logic [4*NUM_SLOTS-1:0]      out_src2,
  output logic [4*NUM_SLOTS-1:0]      out_dest,
  output logic [NUM_SLOTS*DATA_W-1:0] out_data,
  output logic [LVL_W-1:0]            level
);

  localparam int FLD_W   = FIELD_W * NUM_SLOTS;
  localparam int ENTRY_W = 4 * FLD_W + NUM_SLOTS * DATA_W;

  logic [FLD_W-1:0]            dec_op;
  logic [FLD_W-1:0]            dec_src1;
  logic [FLD_W-1:0]            dec_src2;
  logic [FLD_W-1:0]            dec_dest;
  logic [NUM_SLOTS*DATA_W-1:0] dec_data;
  logic [NUM_SLOTS-1:0]        lane_nop;
  logic                        all_nop;
  logic                        keep;
  logic                        push;
  logic                        pop;
  logic                        full;
  logic                        empty;
  logic [ENTRY_W-1:0]          head;
  logic                        unused_top_bits;

  // Lane 0 occupies the most significant slot of the word.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_lane
    localparam int B = SLOT_W * (NUM_SLOTS - 1 - g);
    logic unused_lane_bits;

    assign dec_op[4*g +: 4]   = in_word[B + OPC_OFS  +: FIELD_W];
    assign dec_src1[4*g +: 4] = in_word[B + SRC1_OFS +: FIELD_W];
    assign dec_src2[4*g +: 4] = in_word[B + SRC2_OFS +: FIELD_W];
    assign dec_dest[4*g +: 4] = in_word[B + DEST_OFS +: FIELD_W];
    assign lane_nop[g]        = (dec_op[4*g +: 4] == nop);
    assign dec_data[DATA_W*g +: DATA_W] =
      (dec_op[4*g +: 4] == load) ? in_data[DATA_W*g +: DATA_W] : '0;
    assign unused_lane_bits =
      ^{in_word[B+19], in_word[B+14], in_word[B+9], in_word[B+4]};
  end

  assign unused_top_bits = ^in_word[WORD_W-1 -: RSVD_W];

  assign all_nop   = &lane_nop;
  assign keep      = (DROP_NOP == 1'b0) || !all_nop;
  // No pass-through when full: in_ready looks only at the current level.
  assign in_ready  = reset & ~full;
  assign out_valid = ~empty;
  // A dropped all-NOP bundle still sees in_ready and so completes its handshake.
  assign push      = in_valid & in_ready & ~flush & keep;
  assign pop       = out_valid & out_ready & ~flush;

  vliw_bundle_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .push    (push),
    .wr_data ({dec_op, dec_src1, dec_src2, dec_dest, dec_data}),
    .pop     (pop),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // Never expose stale storage while empty.
  assign {out_op, out_src1, out_src2, out_dest, out_data} = empty ? '0 : head;

endmodule

// File: tb/tb_vliw_fetch_queue.sv
module tb_vliw_fetch_queue;

  localparam int NS    = 3;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int WW    = 20 * NS + 4;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int HW    = 16 * NS + NS * DW;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [WW-1:0]   in_word;
  logic [NS*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [4*NS-1:0] out_op, out_src1, out_src2, out_dest;
  logic [NS*DW-1:0] out_data;
  logic [LW-1:0]   level;

  logic            d_flush;
  logic            d_in_valid;
  logic            d_in_ready;
  logic [WW-1:0]   d_in_word;
  logic [NS*DW-1:0] d_in_data;
  logic            d_out_valid;
  logic            d_out_ready;
  logic [4*NS-1:0] d_out_op, d_out_src1, d_out_src2, d_out_dest;
  logic [NS*DW-1:0] d_out_data;
  logic [LW-1:0]   d_level;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [WW-1:0]    w;
    logic [NS*DW-1:0] d;
  } bundle_t;
  bundle_t mq[$];

  vliw_fetch_queue #(.NUM_SLOTS(NS), .DATA_W(DW), .DEPTH(DEPTH), .DROP_NOP(1'b0)) dut (
    .clock(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_src1(out_src1), .out_src2(out_src2), .out_dest(out_dest),
    .out_data(out_data), .level(level));

  vliw_fetch_queue #(.NUM_SLOTS(NS), .DATA_W(DW), .DEPTH(DEPTH), .DROP_NOP(1'b1)) dut_drop (
    .clock(clk), .reset(reset), .flush(d_flush), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_word(d_in_word), .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_op(d_out_op), .out_src1(d_out_src1), .out_src2(d_out_src2), .out_dest(d_out_dest),
    .out_data(d_out_data), .level(d_level));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    w = {$urandom, $urandom};
    for (int i = 0; i < NS; i++)
      if ($urandom_range(0, 1) == 1) w[20*(NS-1-i)+15 +: 4] = 4'd4;
    return w;
  endfunction

  function automatic logic [NS*DW-1:0] rand_data();
    logic [NS*DW-1:0] d;
    for (int k = 0; k < NS * DW / 32; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  // Expected head outputs: decode the oldest queued bundle from its raw word.
  function automatic logic [HW-1:0] expect_head();
    logic [4*NS-1:0]  op, s1, s2, de;
    logic [NS*DW-1:0] da;
    logic [WW-1:0]    w;
    int b;
    op = '0; s1 = '0; s2 = '0; de = '0; da = '0;
    if (mq.size() == 0) return '0;
    w = mq[0].w;
    for (int i = 0; i < NS; i++) begin
      b = 20 * (NS - 1 - i);
      op[4*i +: 4] = 4'((w >> (b + 15)) & 64'hF);
      s1[4*i +: 4] = 4'((w >> (b + 10)) & 64'hF);
      s2[4*i +: 4] = 4'((w >> (b + 5)) & 64'hF);
      de[4*i +: 4] = 4'((w >> b) & 64'hF);
      if (op[4*i +: 4] == 4'd4) da[DW*i +: DW] = mq[0].d[DW*i +: DW];
    end
    return {op, s1, s2, de, da};
  endfunction

  // Drive one cycle on the main DUT and advance the model across the edge.
  task automatic drive(input logic v, input logic [WW-1:0] w, input logic [NS*DW-1:0] d,
                       input logic ordy, input logic fl);
    bit push, pop;
    bundle_t nb;
    in_valid = v; in_word = w; in_data = d; out_ready = ordy; flush = fl;
    push = reset && v && (mq.size() < DEPTH) && !fl;
    pop  = reset && (mq.size() > 0) && ordy && !fl;
    @(posedge clk);
    if (!reset || fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin nb.w = w; nb.d = d; mq.push_back(nb); end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, rand_word(), rand_data(), 1'b1, 1'b0);
      total++;
      if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
      else passed++;
    end
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else passed++;
    total++;
    if (out_op !== '0) $display("FAIL reset_out_op: got %h want 0", out_op);
    else passed++;
    total++;
    if (level !== '0) $display("FAIL reset_level: got %0d want 0", level);
    else passed++;
    total++;
    if (d_level !== '0 || d_out_valid !== 1'b0)
      $display("FAIL reset_drop_dut: got level %0d valid %b want 0 0", d_level, d_out_valid);
    else passed++;
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++;
    if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_single();
    logic [WW-1:0]    w;
    logic [NS*DW-1:0] d;
    w = '0;
    w[58:55] = 4'b0100; w[53:50] = 4'd3; w[48:45] = 4'd5; w[43:40] = 4'd7;
    w[38:35] = 4'd1;
    d = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h0000_0000_0000_DEAD};
    drive(1'b1, w, d, 1'b0, 1'b0);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid);
    else passed++;
    total++;
    if (out_op[3:0] !== 4'd4 || out_op[7:4] !== 4'd1)
      $display("FAIL single_ops: got lane0 %0d lane1 %0d want 4 1", out_op[3:0], out_op[7:4]);
    else passed++;
    total++;
    if ({out_src1[3:0], out_src2[3:0], out_dest[3:0]} !== {4'd3, 4'd5, 4'd7})
      $display("FAIL single_regs: got %h %h %h want 3 5 7", out_src1[3:0], out_src2[3:0], out_dest[3:0]);
    else passed++;
    total++;
    if (out_data[63:0] !== 64'hDEAD || out_data[191:64] !== '0)
      $display("FAIL single_data: got %h want lane0 dead, others 0", out_data);
    else passed++;
    total++;
    if ({out_op, out_src1, out_src2, out_dest, out_data} !== expect_head())
      $display("FAIL single_head: got %h want %h",
               {out_op, out_src1, out_src2, out_dest, out_data}, expect_head());
    else passed++;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b0 || {out_op, out_src1, out_src2, out_dest, out_data} !== '0)
      $display("FAIL single_empty: got valid %b head %h want 0",
               out_valid, {out_op, out_src1, out_src2, out_dest, out_data});
    else passed++;
  endtask

  task automatic test_fill();
    for (int c = 0; c < 5; c++) drive(1'b1, rand_word(), rand_data(), 1'b0, 1'b0);
    total++;
    if (level !== LW'(4)) $display("FAIL fill_level: got %0d want 4", level);
    else passed++;
    total++;
    if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", in_ready);
    else passed++;
    // pop plus offer while full: no pass-through push
    drive(1'b1, rand_word(), rand_data(), 1'b1, 1'b0);
    total++;
    if (level !== LW'(3) || in_ready !== 1'b1)
      $display("FAIL full_pop_no_push: got level %0d ready %b want 3 1", level, in_ready);
    else passed++;
    in_valid = 1'b0;
    for (int c = 0; c < 8 && mq.size() > 0; c++) begin
      total++;
      if ({out_op, out_src1, out_src2, out_dest, out_data} !== expect_head())
        $display("FAIL drain_order: got %h want %h",
                 {out_op, out_src1, out_src2, out_dest, out_data}, expect_head());
      else passed++;
      drive(1'b0, '0, '0, 1'b1, 1'b0);
    end
    total++;
    if (out_valid !== 1'b0 || level !== '0)
      $display("FAIL drain_empty: got valid %b level %0d want 0 0", out_valid, level);
    else passed++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, rand_word(), rand_data(), 1'b0, 1'b0);
    drive(1'b1, rand_word(), rand_data(), 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, rand_word(), rand_data(), 1'b1, 1'b0);
      total++;
      if (level !== LW'(2)) $display("FAIL stream_level: got %0d want 2", level);
      else passed++;
      total++;
      if ({out_op, out_src1, out_src2, out_dest, out_data} !== expect_head())
        $display("FAIL stream_head: got %h want %h",
                 {out_op, out_src1, out_src2, out_dest, out_data}, expect_head());
      else passed++;
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    logic [WW-1:0] nw;
    for (int c = 0; c < 3; c++) drive(1'b1, rand_word(), rand_data(), 1'b0, 1'b0);
    drive(1'b1, rand_word(), rand_data(), 1'b1, 1'b1);
    total++;
    if (level !== '0 || out_valid !== 1'b0)
      $display("FAIL flush_state: got level %0d valid %b want 0 0", level, out_valid);
    else passed++;
    total++;
    if ({out_op, out_src1, out_src2, out_dest, out_data} !== '0)
      $display("FAIL flush_head: got %h want 0", {out_op, out_src1, out_src2, out_dest, out_data});
    else passed++;
    nw = rand_word();
    drive(1'b1, nw, rand_data(), 1'b0, 1'b0);
    total++;
    if (level !== LW'(1) || {out_op, out_src1, out_src2, out_dest, out_data} !== expect_head())
      $display("FAIL flush_next: got level %0d head %h want 1 %h", level,
               {out_op, out_src1, out_src2, out_dest, out_data}, expect_head());
    else passed++;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, rand_word(), rand_data(), 1'b0, 1'b0);
    drive(1'b1, rand_word(), rand_data(), 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b1, rand_word(), rand_data(), 1'b1, 1'b0);
    total++;
    if (level !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0 ||
        {out_op, out_src1, out_src2, out_dest, out_data} !== '0)
      $display("FAIL reset_mid: got level %0d valid %b ready %b head %h want all 0",
               level, out_valid, in_ready, {out_op, out_src1, out_src2, out_dest, out_data});
    else passed++;
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_drop_nop();
    logic [WW-1:0] nw, aw;
    nw = {$urandom, $urandom};
    for (int i = 0; i < NS; i++) nw[20*(NS-1-i)+15 +: 4] = 4'd0;
    aw = {$urandom, $urandom};
    for (int i = 0; i < NS; i++) aw[20*(NS-1-i)+15 +: 4] = 4'd1;
    d_out_ready = 1'b0;
    d_in_valid = 1'b1; d_in_word = nw; d_in_data = rand_data();
    total++;
    if (d_in_ready !== 1'b1) $display("FAIL drop_nop_ready: got %b want 1", d_in_ready);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (d_level !== '0 || d_out_valid !== 1'b0)
      $display("FAIL drop_nop_dropped: got level %0d valid %b want 0 0", d_level, d_out_valid);
    else passed++;
    d_in_word = aw;
    total++;
    if (d_in_ready !== 1'b1) $display("FAIL drop_add_ready: got %b want 1", d_in_ready);
    else passed++;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    total++;
    if (d_level !== LW'(1) || d_out_op !== {NS{4'd1}} ||
        d_out_src1[3:0] !== aw[20*(NS-1)+10 +: 4])
      $display("FAIL drop_add_head: got level %0d op %h src1 %h want 1 %h %h",
               d_level, d_out_op, d_out_src1[3:0], {NS{4'd1}}, aw[20*(NS-1)+10 +: 4]);
    else passed++;
    // same all-NOP bundle is queued by the non-dropping instance
    drive(1'b1, nw, '0, 1'b0, 1'b0);
    total++;
    if (level !== LW'(1) || out_op !== '0 || out_valid !== 1'b1)
      $display("FAIL keep_nop: got level %0d valid %b op %h want 1 1 0", level, out_valid, out_op);
    else passed++;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      total++;
      if (out_valid !== (mq.size() > 0) || level !== LW'(mq.size()) ||
          in_ready !== (mq.size() < DEPTH))
        $display("FAIL rand_status: cycle %0d got valid %b level %0d ready %b want %b %0d %b",
                 c, out_valid, level, in_ready, mq.size() > 0, mq.size(), mq.size() < DEPTH);
      else passed++;
      total++;
      if ({out_op, out_src1, out_src2, out_dest, out_data} !== expect_head())
        $display("FAIL rand_head: cycle %0d got %h want %h", c,
                 {out_op, out_src1, out_src2, out_dest, out_data}, expect_head());
      else passed++;
      drive(1'($urandom_range(0, 3) != 0), rand_word(), rand_data(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = '0; in_data = '0; out_ready = 1'b0;
    d_flush = 1'b0; d_in_valid = 1'b0; d_in_word = '0; d_in_data = '0; d_out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_drop_nop();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
